// File: rtl/crop_filter.sv
// Streaming region-of-interest crop for raster-order pixel streams.
// One output register stage; kept pixels appear one cycle after acceptance.
module crop_filter #(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int IN_ROWS         = 9,
  parameter int IN_COLS         = 9,
  parameter int OUT_ROWS        = 3,
  parameter int OUT_COLS        = 3,
  parameter int Y_1             = 2,
  parameter int X_1             = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
  localparam logic [RW:0]   ROW_LO   = (RW+1)'(Y_1);
  localparam logic [RW:0]   ROW_N    = (RW+1)'(OUT_ROWS);
  localparam logic [CW:0]   COL_LO   = (CW+1)'(X_1);
  localparam logic [CW:0]   COL_N    = (CW+1)'(OUT_COLS);

  if (Y_1 + OUT_ROWS > IN_ROWS || X_1 + OUT_COLS > IN_COLS ||
      OUT_ROWS < 1 || OUT_COLS < 1 || Y_1 < 0 || X_1 < 0) begin : g_bad_params
    $error("crop_filter: crop window does not fit inside the input frame");
  end

  logic [RW-1:0]              r_row;
  logic [CW-1:0]              r_col;
  logic [PIXEL_BIT_WIDTH-1:0] r_pix;
  logic                       r_vld;

  logic        w_fire;
  logic        w_keep;
  logic [RW:0] w_row_off;
  logic [CW:0] w_col_off;

  // One extra bit makes positions left/above the window wrap to large offsets
  assign w_row_off = {1'b0, r_row} - ROW_LO;
  assign w_col_off = {1'b0, r_col} - COL_LO;
  assign w_keep    = (w_row_off < ROW_N) && (w_col_off < COL_N);

  assign in_ready  = !r_vld || out_ready;
  assign w_fire    = in_valid && in_ready;
  assign pixel_out = r_pix;
  assign out_valid = r_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_fire) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix <= '0;
      r_vld <= 1'b0;
    end else if (w_fire && w_keep) begin
      r_pix <= pixel_in;
      r_vld <= 1'b1;
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crop_filter.sv
// Bench for crop_filter: queue scoreboard driven by frame position,
// directed stall/reset/back-to-back scenarios and a full-frame pass-through.
module tb_crop_filter;

  localparam int W  = 8;
  localparam int IR = 9;
  localparam int IC = 9;
  localparam int OR = 3;
  localparam int OC = 3;
  localparam int Y1 = 2;
  localparam int X1 = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pixel_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] pixel_out;
  logic         out_valid;
  logic         out_ready = 1'b1;

  logic [W-1:0] f_pix = '0;
  logic         f_valid = 1'b0;
  logic         f_iready;
  logic [W-1:0] f_pout;
  logic         f_ovalid;

  int errors = 0;
  int checks = 0;
  int q[$];
  int got[$];
  int idx = 0;
  int ready_low = 0;
  bit pk = 0;
  int pk_data = 0;
  bit ps = 0;
  int ps_data = 0;
  int lit[9] = '{20, 21, 22, 29, 30, 31, 38, 39, 40};

  always #5 clk = ~clk;

  crop_filter #(
    .PIXEL_BIT_WIDTH(W), .IN_ROWS(IR), .IN_COLS(IC),
    .OUT_ROWS(OR), .OUT_COLS(OC), .Y_1(Y1), .X_1(X1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  crop_filter #(
    .PIXEL_BIT_WIDTH(W), .IN_ROWS(9), .IN_COLS(9),
    .OUT_ROWS(9), .OUT_COLS(9), .Y_1(0), .X_1(0)
  ) u_full (
    .clk(clk), .reset(reset),
    .pixel_in(f_pix), .in_valid(f_valid), .in_ready(f_iready),
    .pixel_out(f_pout), .out_valid(f_ovalid), .out_ready(1'b1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position of each accepted pixel decides if it must come out
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      idx = 0;
      pk = 0;
      ps = 0;
      chk("reset_out_valid", int'(out_valid), 0);
    end else begin
      chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      if (ps) begin
        chk("stall_hold_valid", int'(out_valid), 1);
        chk("stall_hold_data", int'(pixel_out), ps_data);
      end
      if (pk) begin
        chk("latency_valid", int'(out_valid), 1);
        chk("latency_data", int'(pixel_out), pk_data);
      end
      if (!in_ready) ready_low++;
      if (out_valid && out_ready) begin
        got.push_back(int'(pixel_out));
        if (q.size() == 0) chk("spurious_output", int'(pixel_out), -1);
        else chk("out_data", int'(pixel_out), q.pop_front());
      end
      pk = 0;
      if (in_valid && in_ready) begin
        int r;
        int c;
        r = idx / IC;
        c = idx % IC;
        if (r >= Y1 && r < Y1 + OR && c >= X1 && c < X1 + OC) begin
          q.push_back(int'(pixel_in));
          pk = 1;
          pk_data = int'(pixel_in);
        end
        idx = (idx + 1) % (IR * IC);
      end
      ps = out_valid && !out_ready;
      ps_data = int'(pixel_out);
    end
  end

  task automatic drive(input int base, input bit rnd,
                       input int stall_at, input int rst_at);
    int i = 0;
    int cyc = 0;
    bit evt = 0;
    while (i < IR * IC) begin
      if (cyc > 3000) begin
        chk("drive_timeout", i, IR * IC);
        break;
      end
      cyc++;
      pixel_in  = W'(base + i);
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk);
      #1;
      if (!evt && i == stall_at) begin
        evt = 1;
        out_ready = 1'b0;
        pixel_in  = W'(base + i);
        repeat (4) begin
          @(negedge clk);
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_pixel", int'(pixel_out), base + stall_at - 1);
          chk("stall_in_ready", int'(in_ready), 0);
          @(posedge clk);
          #1;
        end
      end
      if (!evt && i == rst_at) begin
        evt = 1;
        out_ready = 1'b0;
        pixel_in  = W'(base + i);
        @(negedge clk);
        chk("held_before_reset", int'(pixel_out), base + rst_at - 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", int'(out_valid), 0);
        chk("async_reset_pixel", int'(pixel_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        i = 0;
      end
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string nm, input int nframes);
    chk({nm, "_count"}, got.size(), 9 * nframes);
    chk({nm, "_model_empty"}, q.size(), 0);
    for (int k = 0; k < got.size() && k < 9 * nframes; k++)
      chk({nm, "_value"}, got[k], lit[k % 9] + (k / 9) * 100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pixel_out", int'(pixel_out), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    reset = 1'b0;

    got.delete();
    ready_low = 0;
    drive(0, 1'b0, -1, -1);
    chk("full_rate_in_ready_low", ready_low, 0);
    drain();
    check_got("stream", 1);

    got.delete();
    drive(0, 1'b1, -1, -1);
    drain();
    check_got("random", 1);

    got.delete();
    drive(0, 1'b0, 21, -1);
    drain();
    check_got("stall", 1);

    got.delete();
    drive(0, 1'b0, -1, -1);
    drive(100, 1'b0, -1, -1);
    drain();
    check_got("two_frames", 2);

    got.delete();
    drive(0, 1'b0, -1, 22);
    drain();
    check_got("after_reset", 1);

    for (int i = 0; i <= 81; i++) begin
      f_valid = (i < 81);
      f_pix   = W'(i * 3 + 7);
      @(negedge clk);
      chk("pass_in_ready", int'(f_iready), 1);
      if (i > 0) begin
        chk("pass_valid", int'(f_ovalid), 1);
        chk("pass_data", int'(f_pout), (i - 1) * 3 + 7);
      end
      @(posedge clk);
      #1;
    end
    f_valid = 1'b0;
    @(negedge clk);
    chk("pass_idle", int'(f_ovalid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
